dac_serial_writer: RTL and testbench

//  Serial-write controller for NUMDACS AD5300-class 8-bit DACs, the output counterpart of the rail-sense ADC readers.
//  - All DACs share one SYNC and one SCLK. Each DAC has its own DIN line.
//  - On one valid/ready handshake, the block accepts one 8-bit code per DAC and shifts all 16-bit frames out in parallel.
//  - Sits between rover control logic (setpoints, reference trims) and the board-level DAC pins.

---
 rtl/dac_serial_writer_pkg.sv | 29 ++
 rtl/dac_serial_writer_clk_div.sv | 32 +++
 rtl/dac_serial_writer.sv | 143 ++++++++++++++
 tb/tb_dac_serial_writer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dac_serial_writer_pkg.sv
// Shared types for the AD5300-class serial DAC writer: frame word, power-down
// modes, FSM states and the frame-building helper.
package dac_serial_writer_pkg;

   localparam int DAC_FRAME_BITS = 16;

   typedef logic [7:0]                bus08_t;
   typedef logic [DAC_FRAME_BITS-1:0] dacFrame_t;

   typedef enum logic [1:0] {
      PD_NORMAL = 2'b00,
      PD_1K     = 2'b01,
      PD_100K   = 2'b10,
      PD_TRI    = 2'b11
   } dacPd_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SETUP = 2'b01,
      ST_SHIFT = 2'b10,
      ST_GAP   = 2'b11
   } dac_state_t;

   // AD5300 input word: two don't-care zeros, PD bits, code, four trailing zeros
   function automatic dacFrame_t mkDacFrame(input dacPd_t pd, input bus08_t code);
      return {2'b00, pd, code, 4'b0000};
   endfunction

endpackage

// File: rtl/dac_serial_writer_clk_div.sv
// Half-period tick generator for the DAC serial clock; the count is held at
// zero while disabled so every enable starts a fresh DIV-cycle interval.
module dac_clk_div #(
   parameter int DIV = 5
) (
   input  logic sclk,
   input  logic rstn,
   input  logic enable,
   output logic tick
);

   localparam int             CW   = $clog2(DIV + 1);
   localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_r;

   // Free-running 0..DIV-1 counter, cleared whenever the FSM is idle
   always_ff @(posedge sclk or negedge rstn) begin
      if (!rstn) begin
         cnt_r <= {CW{1'b0}};
      end else if (!enable) begin
         cnt_r <= {CW{1'b0}};
      end else if (cnt_r == LAST) begin
         cnt_r <= {CW{1'b0}};
      end else begin
         cnt_r <= cnt_r + CW'(1);
      end
   end

   assign tick = enable && (cnt_r == LAST);

endmodule

// File: rtl/dac_serial_writer.sv
// Parallel serial-write controller for NUMDACS AD5300-class DACs sharing SYNC/SCLK.
// Optional feature: define DAC_PWRDN_EN to add the pdMode power-down input.
module dac_serial_writer
   import dac_serial_writer_pkg::*;
#(
   parameter int SYSCLK_FREQ = 100_000_000,
   parameter int DAC_SCLK    = 10_000_000,
   parameter int NUMDACS     = 5
) (
   input  logic                 sclk,
   input  logic                 rstn,
   input  bus08_t [NUMDACS-1:0] inData,
`ifdef DAC_PWRDN_EN
   input  dacPd_t               pdMode,
`endif
   input  logic                 inValid,
   output logic                 inReady,
   output logic                 frameDone,
   output logic                 syncn,
   output logic                 dclk,
   output logic [NUMDACS-1:0]   sdin
);

   localparam int DIV = SYSCLK_FREQ / (2 * DAC_SCLK);

   dac_state_t              state_r,  state_nx_s;
   logic                    half_r,   half_nx_s;
   logic [3:0]              bit_r,    bit_nx_s;
   dacFrame_t [NUMDACS-1:0] shreg_r,  shreg_nx_s;
   logic                    tick_s;
   dacPd_t                  pd_s;
   logic                    active_nx_s;

`ifdef DAC_PWRDN_EN
   assign pd_s = pdMode;
`else
   assign pd_s = PD_NORMAL;
`endif

   dac_clk_div #(.DIV(DIV)) u_clk_div (
      .sclk   (sclk),
      .rstn   (rstn),
      .enable (state_r != ST_IDLE),
      .tick   (tick_s)
   );

   // FSM state, phase, bit count and per-DAC shift registers
   always_ff @(posedge sclk or negedge rstn) begin
      if (!rstn) begin
         state_r <= ST_IDLE;
         half_r  <= 1'b0;
         bit_r   <= 4'd0;
         shreg_r <= {(NUMDACS*DAC_FRAME_BITS){1'b0}};
      end else begin
         state_r <= state_nx_s;
         half_r  <= half_nx_s;
         bit_r   <= bit_nx_s;
         shreg_r <= shreg_nx_s;
      end
   end

   // Next-state logic; half_r=0 is the dclk-low phase of the current bit
   always_comb begin
      state_nx_s = state_r;
      half_nx_s  = half_r;
      bit_nx_s   = bit_r;
      shreg_nx_s = shreg_r;
      case (state_r)
         ST_IDLE: begin
            if (inValid && inReady) begin
               state_nx_s = ST_SETUP;
               half_nx_s  = 1'b0;
               bit_nx_s   = 4'd0;
               for (int i = 0; i < NUMDACS; i++) begin
                  shreg_nx_s[i] = mkDacFrame(pd_s, inData[i]);
               end
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_SETUP: begin
            if (tick_s) begin
               state_nx_s = ST_SHIFT;
               half_nx_s  = 1'b0;
            end else begin
               state_nx_s = ST_SETUP;
            end
         end
         ST_SHIFT: begin
            if (!tick_s) begin
               state_nx_s = ST_SHIFT;
            end else if (!half_r) begin
               // Rising dclk: present the next bit, but hold the last one
               half_nx_s = 1'b1;
               if (bit_r != 4'd15) begin
                  for (int i = 0; i < NUMDACS; i++) begin
                     shreg_nx_s[i] = {shreg_r[i][DAC_FRAME_BITS-2:0], 1'b0};
                  end
               end else begin
                  shreg_nx_s = shreg_r;
               end
            end else if (bit_r == 4'd15) begin
               state_nx_s = ST_GAP;
            end else begin
               half_nx_s = 1'b0;
               bit_nx_s  = bit_r + 4'd1;
            end
         end
         ST_GAP: begin
            if (tick_s) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_GAP;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   assign active_nx_s = (state_nx_s == ST_SETUP) || (state_nx_s == ST_SHIFT);

   // Pins are registered from the next state so they change cleanly on one edge
   always_ff @(posedge sclk or negedge rstn) begin
      if (!rstn) begin
         syncn     <= 1'b1;
         dclk      <= 1'b1;
         sdin      <= {NUMDACS{1'b0}};
         frameDone <= 1'b0;
         inReady   <= 1'b0;
      end else begin
         syncn     <= !active_nx_s;
         dclk      <= !((state_nx_s == ST_SHIFT) && !half_nx_s);
         for (int i = 0; i < NUMDACS; i++) begin
            sdin[i] <= active_nx_s ? shreg_nx_s[i][DAC_FRAME_BITS-1] : 1'b0;
         end
         frameDone <= (state_r == ST_SHIFT) && (state_nx_s == ST_GAP);
         inReady   <= (state_nx_s == ST_IDLE);
      end
   end

endmodule

// File: tb/tb_dac_serial_writer.sv
// Self-checking bench for dac_serial_writer (DIV=5, NUMDACS=2) with a serial
// DAC model that samples sdin on every dclk falling edge while syncn is low.
module tb_dac_serial_writer;
   import dac_serial_writer_pkg::*;

   localparam int DIV    = 5;
   localparam int LOWCYC = 33 * DIV;
   localparam int PERIOD = 34 * DIV + 1;

   logic           sclk    = 1'b0;
   logic           rstn    = 1'b0;
   logic           inValid = 1'b0;
   bus08_t [1:0]   inData  = '0;
`ifdef DAC_PWRDN_EN
   dacPd_t         pdMode  = PD_NORMAL;
`endif
   logic           inReady, frameDone, syncn, dclk;
   logic [1:0]     sdin;

   dac_serial_writer #(
      .SYSCLK_FREQ (100_000_000),
      .DAC_SCLK    (10_000_000),
      .NUMDACS     (2)
   ) dut (
      .sclk      (sclk),
      .rstn      (rstn),
      .inData    (inData),
`ifdef DAC_PWRDN_EN
      .pdMode    (pdMode),
`endif
      .inValid   (inValid),
      .inReady   (inReady),
      .frameDone (frameDone),
      .syncn     (syncn),
      .dclk      (dclk),
      .sdin      (sdin)
   );

   always #5 sclk = ~sclk;

   int cyc = 0;
   always @(posedge sclk) cyc <= cyc + 1;

   // Output monitor sampled on the falling system-clock edge
   int   low_cnt = 0;
   int   fd_cyc  = -1;
   int   rdy_cyc = -1;
   logic rdy_q   = 1'b0;
   always @(negedge sclk) begin
      if (syncn === 1'b0) low_cnt++;
      if (frameDone === 1'b1) fd_cyc = cyc;
      if (inReady === 1'b1 && rdy_q !== 1'b1) rdy_cyc = cyc;
      rdy_q = inReady;
   end

   // Serial DAC model: a frame counts only with exactly 16 falling edges
   logic        syncn_q = 1'b1;
   logic        dclk_q  = 1'b1;
   logic [15:0] rx [2];
   logic [31:0] got [64];
   int          ecnt = 0, edges_last = 0, nframes = 0, discards = 0;
   always @(dclk or syncn) begin
      if (syncn_q === 1'b1 && syncn === 1'b0) begin
         ecnt = 0;
      end else if (syncn_q === 1'b0 && syncn === 1'b1) begin
         edges_last = ecnt;
         if (ecnt == 16) begin
            if (nframes < 64) got[nframes] = {rx[1], rx[0]};
            nframes++;
         end else begin
            discards++;
         end
      end
      if (dclk_q === 1'b1 && dclk === 1'b0 && syncn === 1'b0) begin
         for (int i = 0; i < 2; i++) rx[i] = {rx[i][14:0], sdin[i]};
         ecnt++;
      end
      syncn_q = syncn;
      dclk_q  = dclk;
   end

   int checks = 0, failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send(input bus08_t c1, input bus08_t c0, output int e);
      int n = 0;
      @(negedge sclk);
      while (inReady !== 1'b1 && n < 400) begin
         @(negedge sclk);
         n++;
      end
      chk("ready_before_send", inReady, 1'b1);
      inData  = {c1, c0};
      inValid = 1'b1;
      e       = cyc + 1;
      @(negedge sclk);
      inValid = 1'b0;
   endtask

   // Sends one frame and checks data, edge count and all frame timing
   task automatic frame_test(input string name, input bus08_t c1, input bus08_t c0,
                             input logic [15:0] e1, input logic [15:0] e0);
      int e, lc0, nf0;
      lc0 = low_cnt;
      nf0 = nframes;
      send(c1, c0, e);
      repeat (PERIOD + 4) @(negedge sclk);
      chk({name, "_nframes"}, nframes - nf0, 1);
      chk({name, "_data"}, got[nf0], {e1, e0});
      chk({name, "_edges"}, edges_last, 16);
      chk({name, "_synclow"}, low_cnt - lc0, LOWCYC);
      chk({name, "_done_at"}, fd_cyc - e, LOWCYC);
      chk({name, "_ready_at"}, rdy_cyc - e, PERIOD - 1);
   endtask

   typedef struct {
      bus08_t      c1;
      bus08_t      c0;
      logic [15:0] e1;
      logic [15:0] e0;
   } vec_t;

   vec_t        tbl [5];
   int          e, nf0, lc0, dc0;
   int          acc [$];
   logic [31:0] expq [$];
   logic [15:0] exp80;

   initial begin
      tbl[0] = '{8'hA5, 8'h3C, 16'h0A50, 16'h03C0};
      tbl[1] = '{8'h00, 8'hFF, 16'h0000, 16'h0FF0};
      tbl[2] = '{8'hFF, 8'h00, 16'h0FF0, 16'h0000};
      tbl[3] = '{8'h80, 8'h01, 16'h0800, 16'h0010};
      tbl[4] = '{8'h12, 8'hEF, 16'h0120, 16'h0EF0};

      // Reset state and first ready edge
      repeat (3) @(negedge sclk);
      chk("reset_pins", {syncn, dclk, sdin, frameDone, inReady}, 6'b110000);
      rstn = 1'b1;
      #1;
      chk("ready_low_after_release", inReady, 1'b0);
      @(negedge sclk);
      chk("ready_first_edge", inReady, 1'b1);

      for (int k = 0; k < 5; k++) begin
         frame_test($sformatf("vec%0d", k), tbl[k].c1, tbl[k].c0, tbl[k].e1, tbl[k].e0);
      end

      // Back-to-back: inValid held high while data changes every cycle
      nf0 = nframes;
      for (int k = 0; k < 400; k++) begin
         bus08_t a, b;
         @(negedge sclk);
         a = bus08_t'(k * 7 + 3);
         b = bus08_t'(k * 13 + 1);
         inData  = {a, b};
         inValid = 1'b1;
         if (inReady === 1'b1) begin
            acc.push_back(cyc + 1);
            expq.push_back({4'h0, a, 4'h0, 4'h0, b, 4'h0});
         end
      end
      inValid = 1'b0;
      repeat (180) @(negedge sclk);
      chk("b2b_accepts", acc.size(), 3);
      for (int j = 1; j < acc.size(); j++) chk("b2b_period", acc[j] - acc[j-1], PERIOD);
      chk("b2b_nframes", nframes - nf0, expq.size());
      for (int j = 0; j < expq.size(); j++) chk("b2b_data", got[nf0 + j], expq[j]);

      // Mid-frame valid pulse with new data is ignored
      nf0 = nframes;
      lc0 = low_cnt;
      send(8'h5A, 8'hC3, e);
      repeat (60) @(negedge sclk);
      inData  = {8'h11, 8'h22};
      inValid = 1'b1;
      @(negedge sclk);
      inValid = 1'b0;
      inData  = {8'h33, 8'h44};
      repeat (300) @(negedge sclk);
      chk("midpulse_nframes", nframes - nf0, 1);
      chk("midpulse_data", got[nf0], 32'h05A0_0C30);
      chk("midpulse_synclow", low_cnt - lc0, LOWCYC);

      // Reset during bit 7 of the shift phase
      nf0 = nframes;
      dc0 = discards;
      send(8'hF0, 8'h0F, e);
      while (cyc < e + 78) @(negedge sclk);
      chk("prereset_synclow", syncn, 1'b0);
      rstn = 1'b0;
      #1;
      chk("midreset_pins", {syncn, dclk, sdin, frameDone, inReady}, 6'b110000);
      @(negedge sclk);
      rstn = 1'b1;
      @(negedge sclk);
      chk("postreset_ready", inReady, 1'b1);
      chk("aborted_nframes", nframes - nf0, 0);
      chk("aborted_discards", discards - dc0, 1);
      repeat (200) @(negedge sclk);
      chk("aborted_not_resumed", nframes - nf0, 0);
      frame_test("after_reset", 8'h3C, 8'hA5, 16'h03C0, 16'h0A50);

      // Power-down bits from pdMode when the option is built in
`ifdef DAC_PWRDN_EN
      pdMode = PD_TRI;
      exp80  = 16'h3800;
`else
      exp80  = 16'h0800;
`endif
      frame_test("pd_code80", 8'h80, 8'h80, exp80, exp80);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
